// File: rtl/stagemem_pkg.sv
// Shared definitions for the memory stage: RV32I load/store funct3 codes and
// the APB transfer state encoding.
package stagemem_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/stagemem_apb_lsu_format.sv
// Combinational load/store formatting: legality and alignment of the incoming
// request, store lane/strobe generation, and load extraction with extension.
module lsu_format
   import stagemem_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  req_funct3,
   input  logic [1:0]  req_off,
   input  logic [31:0] st_data,
   output logic        acc_ok,
   output logic [3:0]  st_strb,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_raw,
   output logic [31:0] ld_fmt
);

   logic               legal;
   logic               aligned;
   logic [31:0]        ld_shift;
   logic signed [7:0]  ld_byte;
   logic signed [15:0] ld_half;

   always_comb begin
      legal    = 1'b0;
      aligned  = 1'b1;
      st_strb  = 4'b1111;
      st_wdata = st_data << {req_off, 3'b000};

      if (is_store)
         legal = (req_funct3 == SB) || (req_funct3 == SH) || (req_funct3 == SW);
      else
         legal = (req_funct3 == LB) || (req_funct3 == LH) || (req_funct3 == LW) ||
                 (req_funct3 == LBU) || (req_funct3 == LHU);

      // funct3[1:0] encodes access size for both loads and stores
      case (req_funct3[1:0])
         2'b00: begin
            aligned = 1'b1;
            st_strb = 4'b0001 << req_off;
         end
         2'b01: begin
            aligned = ~req_off[0];
            st_strb = 4'b0011 << req_off;
         end
         default: begin
            aligned = (req_off == 2'b00);
            st_strb = 4'b1111;
         end
      endcase

      acc_ok = legal & aligned;
   end

   always_comb begin
      ld_shift = ld_raw >> {ld_off, 3'b000};
      ld_byte  = ld_shift[7:0];
      ld_half  = ld_shift[15:0];
      case (ld_funct3)
         LB:      ld_fmt = 32'(ld_byte);
         LH:      ld_fmt = 32'(ld_half);
         LBU:     ld_fmt = {24'h000000, ld_shift[7:0]};
         LHU:     ld_fmt = {16'h0000, ld_shift[15:0]};
         default: ld_fmt = ld_shift;
      endcase
   end

endmodule

// File: rtl/stagemem_apb.sv
// MEM stage: issues RV32I loads/stores as APB transfers, stalls the pipeline
// while a transfer is in flight, and returns formatted load data.
module stagemem_apb
   import stagemem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_valid_mem,
   input  logic        i_mem_rden,
   input  logic        i_mem_wren,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_alu_data,
   input  logic [31:0] i_rs2_data,
   output logic        o_stall,
   output logic [31:0] o_ld_data,
   output logic        o_ld_valid,
   output logic        o_mem_err,
   output logic        o_psel,
   output logic        o_penable,
   output logic        o_pwrite,
   output logic [31:0] o_paddr,
   output logic [31:0] o_pwdata,
   output logic [3:0]  o_pstrb,
   input  logic        i_pready,
   input  logic [31:0] i_prdata,
   input  logic        i_pslverr
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t           state;
   logic [CNT_W-1:0] to_cnt;
   logic [2:0]       funct3_p1;
   logic [1:0]       off_p1;

   logic             req;
   logic             is_store;
   logic             acc_ok;
   logic [3:0]       st_strb;
   logic [31:0]      st_wdata;
   logic [31:0]      ld_fmt;

   // A request with both rden and wren set is treated as a store
   assign req      = i_valid_mem & (i_mem_rden | i_mem_wren);
   assign is_store = i_mem_wren;
   assign o_stall  = ((state == IDLE) & req & acc_ok) | (state == SETUP) | (state == ACCESS);

   lsu_format u_fmt (
      .is_store   (is_store),
      .req_funct3 (i_funct3),
      .req_off    (i_alu_data[1:0]),
      .st_data    (i_rs2_data),
      .acc_ok     (acc_ok),
      .st_strb    (st_strb),
      .st_wdata   (st_wdata),
      .ld_funct3  (funct3_p1),
      .ld_off     (off_p1),
      .ld_raw     (i_prdata),
      .ld_fmt     (ld_fmt)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         to_cnt     <= '0;
         funct3_p1  <= '0;
         off_p1     <= '0;
         o_psel     <= 1'b0;
         o_penable  <= 1'b0;
         o_pwrite   <= 1'b0;
         o_paddr    <= '0;
         o_pwdata   <= '0;
         o_pstrb    <= '0;
         o_ld_data  <= '0;
         o_ld_valid <= 1'b0;
         o_mem_err  <= 1'b0;
      end else begin
         o_ld_valid <= 1'b0;
         o_mem_err  <= 1'b0;
         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (req) begin
                  if (acc_ok) begin
                     o_psel    <= 1'b1;
                     o_pwrite  <= is_store;
                     o_paddr   <= {i_alu_data[31:2], 2'b00};
                     o_pwdata  <= st_wdata;
                     o_pstrb   <= is_store ? st_strb : 4'b0000;
                     funct3_p1 <= i_funct3;
                     off_p1    <= i_alu_data[1:0];
                     state     <= SETUP;
                  end else begin
                     o_mem_err <= 1'b1;
                  end
               end
            end
            SETUP: begin
               o_penable <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (i_pready) begin
                  o_psel    <= 1'b0;
                  o_penable <= 1'b0;
                  o_mem_err <= i_pslverr;
                  if (!o_pwrite && !i_pslverr) begin
                     o_ld_data  <= ld_fmt;
                     o_ld_valid <= 1'b1;
                  end
                  state <= DONE;
               end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  // Slave never answered: abandon the transfer and flag it
                  o_psel    <= 1'b0;
                  o_penable <= 1'b0;
                  o_mem_err <= 1'b1;
                  state     <= DONE;
               end else begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stagemem_apb.sv
// Directed bench for stagemem_apb: a transaction-level model expands each
// request into expected per-cycle outputs, checked on every falling edge.
module tb_stagemem_apb;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_valid_mem = 1'b0;
   logic        i_mem_rden = 1'b0;
   logic        i_mem_wren = 1'b0;
   logic [2:0]  i_funct3 = 3'b000;
   logic [31:0] i_alu_data = '0;
   logic [31:0] i_rs2_data = '0;
   logic        i_pready = 1'b0;
   logic [31:0] i_prdata = '0;
   logic        i_pslverr = 1'b0;
   logic        o_stall, o_ld_valid, o_mem_err, o_psel, o_penable, o_pwrite;
   logic [31:0] o_ld_data, o_paddr, o_pwdata;
   logic [3:0]  o_pstrb;

   always #5 clk = ~clk;

   stagemem_apb #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_valid_mem(i_valid_mem),
      .i_mem_rden(i_mem_rden), .i_mem_wren(i_mem_wren), .i_funct3(i_funct3),
      .i_alu_data(i_alu_data), .i_rs2_data(i_rs2_data), .o_stall(o_stall),
      .o_ld_data(o_ld_data), .o_ld_valid(o_ld_valid), .o_mem_err(o_mem_err),
      .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
      .o_paddr(o_paddr), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
      .i_pready(i_pready), .i_prdata(i_prdata), .i_pslverr(i_pslverr)
   );

   typedef struct {
      logic [31:0] stall, psel, penable, ld_valid, mem_err, ld_data;
      logic [31:0] apb, rd, paddr, pwdata, pstrb, pwrite;
   } exp_t;

   exp_t        expq[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          stall_seen = 0;
   logic [31:0] model_ld = '0;
   logic [31:0] last_paddr = '0, last_pwdata = '0, last_pstrb = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] stall, psel, pen, ldv, err);
      exp_t e;
      e.stall = stall; e.psel = psel; e.penable = pen; e.ld_valid = ldv;
      e.mem_err = err; e.ld_data = model_ld; e.apb = 0; e.rd = 0;
      e.paddr = 0; e.pwdata = 0; e.pstrb = 0; e.pwrite = 0;
      return e;
   endfunction

   // Compare process: one expected record per cycle while a transaction runs
   always @(negedge clk) begin
      exp_t e;
      if (o_psel) begin
         last_paddr  = o_paddr;
         last_pwdata = o_pwdata;
         last_pstrb  = 32'(o_pstrb);
      end
      if (expq.size() > 0) begin
         e = expq.pop_front();
         if (o_stall) stall_seen++;
         chk("stall",    32'(o_stall),    e.stall);
         chk("psel",     32'(o_psel),     e.psel);
         chk("penable",  32'(o_penable),  e.penable);
         chk("ld_valid", 32'(o_ld_valid), e.ld_valid);
         chk("mem_err",  32'(o_mem_err),  e.mem_err);
         chk("ld_data",  o_ld_data,       e.ld_data);
         if (e.apb != 0) begin
            chk("paddr",  o_paddr,         e.paddr);
            chk("pstrb",  32'(o_pstrb),    e.pstrb);
            chk("pwrite", 32'(o_pwrite),   e.pwrite);
            if (e.rd == 0) chk("pwdata", o_pwdata, e.pwdata);
         end
      end
   end

   // Expand one request into its expected cycle timeline, then drive it
   task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] prd, input int waits, input logic slverr,
                          input int exp_stalls);
      logic        legal;
      logic [31:0] off, sz, b, h, val, strb, wdata;
      int          n_acc, n_rec, hold;
      logic        err;
      exp_t        e;
      off = 32'(addr[1:0]);
      sz  = 32'(f3[1:0]);
      if (wr) legal = (f3 <= 3'd2);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      if (sz == 1 && addr[0]) legal = 1'b0;
      if (sz == 2 && addr[1:0] != 2'b00) legal = 1'b0;
      b = (prd >> (8 * off)) & 32'hFF;
      h = (prd >> (8 * off)) & 32'hFFFF;
      case (f3)
         3'd0:    val = (b >= 128) ? (b | 32'hFFFFFF00) : b;
         3'd1:    val = (h >= 32768) ? (h | 32'hFFFF0000) : h;
         3'd4:    val = b;
         3'd5:    val = h;
         default: val = prd;
      endcase
      strb  = (sz == 0) ? (32'd1 << off) : (sz == 1) ? (32'd3 << off) : 32'd15;
      wdata = rs2 << (8 * off);

      if (!legal) begin
         expq.push_back(mk(0, 0, 0, 0, 0));
         expq.push_back(mk(0, 0, 0, 0, 1));
         expq.push_back(mk(0, 0, 0, 0, 0));
         hold = 1;
      end else begin
         n_acc = (waits >= TO) ? TO : waits + 1;
         err   = (waits >= TO) || slverr;
         expq.push_back(mk(1, 0, 0, 0, 0));
         for (int k = 0; k < n_acc + 1; k++) begin
            e = mk(1, 1, (k > 0) ? 1 : 0, 0, 0);
            e.apb = 1; e.rd = wr ? 0 : 1;
            e.paddr = {addr[31:2], 2'b00};
            e.pstrb = wr ? strb : 0;
            e.pwdata = wdata;
            e.pwrite = wr ? 1 : 0;
            expq.push_back(e);
         end
         if (!wr && !err) model_ld = val;
         expq.push_back(mk(0, 0, 0, (!wr && !err) ? 1 : 0, err ? 1 : 0));
         expq.push_back(mk(0, 0, 0, 0, 0));
         hold = n_acc + 3;
      end
      n_rec = expq.size();

      stall_seen = 0;
      i_funct3 = f3; i_alu_data = addr; i_rs2_data = rs2;
      i_prdata = prd; i_pslverr = slverr;
      for (int c = 0; c < n_rec; c++) begin
         i_valid_mem = (c < hold);
         i_mem_rden  = (c < hold) ? rd : 1'b0;
         i_mem_wren  = (c < hold) ? wr : 1'b0;
         i_pready    = legal && (c == 2 + waits);
         @(posedge clk); #1;
      end
      i_pready = 1'b0; i_pslverr = 1'b0;
      chk("stall_count", 32'(stall_seen), 32'(exp_stalls));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_psel",     32'(o_psel),     0);
      chk("rst_penable",  32'(o_penable),  0);
      chk("rst_pwrite",   32'(o_pwrite),   0);
      chk("rst_paddr",    o_paddr,         0);
      chk("rst_pwdata",   o_pwdata,        0);
      chk("rst_pstrb",    32'(o_pstrb),    0);
      chk("rst_ld_data",  o_ld_data,       0);
      chk("rst_ld_valid", 32'(o_ld_valid), 0);
      chk("rst_mem_err",  32'(o_mem_err),  0);
      i_reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_stall",   32'(o_stall),    0);

      // rd, wr, funct3, addr, rs2, prdata, waits, slverr, stall cycles
      run_txn(0, 1, 3'd2, 32'h1000_0006, 32'h1234_5678, 32'h0,         0,   0, 0);
      run_txn(0, 1, 3'd2, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0,         0,   0, 3);
      chk("sw_paddr_lit",  last_paddr,  32'h1000_0004);
      chk("sw_pwdata_lit", last_pwdata, 32'hDEAD_BEEF);
      chk("sw_pstrb_lit",  last_pstrb,  32'hF);
      run_txn(1, 0, 3'd0, 32'h2000_0003, 32'h0,         32'h80FF_1234, 0,   0, 3);
      chk("lb_lit",  o_ld_data, 32'hFFFF_FF80);
      run_txn(1, 0, 3'd4, 32'h2000_0003, 32'h0,         32'h80FF_1234, 0,   0, 3);
      chk("lbu_lit", o_ld_data, 32'h0000_0080);
      run_txn(1, 0, 3'd1, 32'h2000_0002, 32'h0,         32'h80FF_1234, 1,   0, 4);
      chk("lh_lit",  o_ld_data, 32'hFFFF_80FF);
      run_txn(0, 1, 3'd1, 32'h2000_0002, 32'h0000_ABCD, 32'h0,         0,   0, 3);
      chk("sh_pwdata_lit", last_pwdata, 32'hABCD_0000);
      chk("sh_pstrb_lit",  last_pstrb,  32'hC);
      run_txn(1, 1, 3'd0, 32'h5000_0001, 32'h1122_3344, 32'h0,         0,   0, 3);
      chk("sb_both_pwdata_lit", last_pwdata, 32'h2233_4400);
      chk("sb_both_pstrb_lit",  last_pstrb,  32'h2);
      run_txn(1, 0, 3'd5, 32'h3000_0000, 32'h0,         32'h0000_F00D, 2,   0, 5);
      chk("lhu_lit", o_ld_data, 32'h0000_F00D);
      run_txn(1, 0, 3'd2, 32'h3000_0010, 32'h0,         32'h1111_1111, 100, 0, 18);
      chk("timeout_keep_lit", o_ld_data, 32'h0000_F00D);
      run_txn(1, 0, 3'd2, 32'h3000_0014, 32'h0,         32'h2222_2222, 0,   1, 3);
      chk("slverr_keep_lit", o_ld_data, 32'h0000_F00D);
      run_txn(1, 0, 3'd3, 32'h3000_0018, 32'h0,         32'h0,         0,   0, 0);
      run_txn(1, 0, 3'd1, 32'h3000_0019, 32'h0,         32'h0,         0,   0, 0);
      run_txn(1, 0, 3'd2, 32'h6000_0008, 32'h0,         32'hCAFE_BABE, 1,   0, 4);
      chk("lw_lit", o_ld_data, 32'hCAFE_BABE);

      // Reset arriving while a store sits in ACCESS
      i_valid_mem = 1'b1; i_mem_wren = 1'b1; i_funct3 = 3'd2;
      i_alu_data = 32'h4000_0000; i_rs2_data = 32'h5555_AAAA; i_pready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_mid_in_access", 32'(o_penable), 1);
      i_reset = 1'b1; i_valid_mem = 1'b0; i_mem_wren = 1'b0;
      @(posedge clk); #1;
      i_reset = 1'b0;
      chk("rst_mid_psel",     32'(o_psel),     0);
      chk("rst_mid_penable",  32'(o_penable),  0);
      chk("rst_mid_stall",    32'(o_stall),    0);
      chk("rst_mid_ld_valid", 32'(o_ld_valid), 0);
      chk("rst_mid_mem_err",  32'(o_mem_err),  0);
      chk("rst_mid_ld_data",  o_ld_data,       0);
      @(posedge clk); #1;
      chk("rst_after_psel",     32'(o_psel),     0);
      chk("rst_after_ld_valid", 32'(o_ld_valid), 0);
      chk("rst_after_mem_err",  32'(o_mem_err),  0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
